// File: rtl/fetch_queue_if.sv
// Handshake bundle between fetch, the fetch queue and decode.
// The queue uses the slave modport; the fetch/decode side (or a bench) uses master.
interface fetch_queue_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  // Fetch side
  logic          f_valid_in;
  logic          f_ready_out;
  logic [AW-1:0] f_instr_addr_in;
  logic [DW-1:0] f_instr_dat_in;
  // Decode side
  logic          d_valid_out;
  logic          d_ready_in;
  logic [AW-1:0] d_instr_addr_out;
  logic [DW-1:0] d_instr_dat_out;

  modport master (
    output f_valid_in, f_instr_addr_in, f_instr_dat_in, d_ready_in,
    input  f_ready_out, d_valid_out, d_instr_addr_out, d_instr_dat_out
  );

  modport slave (
    input  f_valid_in, f_instr_addr_in, f_instr_dat_in, d_ready_in,
    output f_ready_out, d_valid_out, d_instr_addr_out, d_instr_dat_out
  );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: FIFO of {instr_addr, instr_dat} pairs between fetch and decode.
// Head outputs are driven straight from storage so consecutive entries flow
// without bubbles. A taken jump (flush_in) empties the queue on the next edge.
// Optional feature macro: FETCH_QUEUE_BYPASS_EN -- when the queue is empty the
// fetch input is forwarded combinationally to decode (0-cycle latency); an
// entry consumed that way is never written.
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush_in,
  fetch_queue_if.slave             bus,
  output logic [$clog2(DEPTH):0]   count_out
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [PW-1:0] PTR_ONE = {{(PW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [AW-1:0] addr_mem_r [DEPTH];
  logic [DW-1:0] dat_mem_r  [DEPTH];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;

  logic          f_ready_s;
  logic          d_valid_s;
  logic [AW-1:0] head_addr_s;
  logic [DW-1:0] head_dat_s;
  logic          push_s;
  logic          pop_s;
  logic          wr_en_s;
  logic          rd_en_s;
  logic          bypass_s;

  // Head selection and valid generation (storage head, or forwarded input when bypassing)
  always_comb begin
    f_ready_s   = ~rst & (count_r != CNT_FULL);
    bypass_s    = 1'b0;
    d_valid_s   = 1'b0;
    head_addr_s = addr_mem_r[rd_ptr_r];
    head_dat_s  = dat_mem_r[rd_ptr_r];
`ifdef FETCH_QUEUE_BYPASS_EN
    bypass_s = (count_r == {CW{1'b0}}) & bus.f_valid_in;
    if (bypass_s) begin
      d_valid_s   = ~flush_in & ~rst;
      head_addr_s = bus.f_instr_addr_in;
      head_dat_s  = bus.f_instr_dat_in;
    end else begin
      d_valid_s   = (count_r != {CW{1'b0}}) & ~flush_in & ~rst;
    end
`else
    d_valid_s = (count_r != {CW{1'b0}}) & ~flush_in & ~rst;
`endif
  end

  // Transfer qualification: which handshakes fire and what they do to storage
  always_comb begin
    push_s = bus.f_valid_in & f_ready_s & ~flush_in;
    pop_s  = d_valid_s & bus.d_ready_in & ~flush_in;
    if (bypass_s & bus.d_ready_in) begin
      // Forwarded entry is consumed directly; storage is untouched.
      wr_en_s = 1'b0;
      rd_en_s = 1'b0;
    end else begin
      wr_en_s = push_s;
      rd_en_s = pop_s & ~bypass_s;
    end
  end

  // Pointer and occupancy tracking; count is kept separately from the pointers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else if (flush_in) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (wr_en_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (rd_en_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      case ({wr_en_s, rd_en_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage; cleared on reset, written at the tail on an accepted push
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_mem_r[i] <= {AW{1'b0}};
        dat_mem_r[i]  <= {DW{1'b0}};
      end
    end else if (wr_en_s) begin
      addr_mem_r[wr_ptr_r] <= bus.f_instr_addr_in;
      dat_mem_r[wr_ptr_r]  <= bus.f_instr_dat_in;
    end else begin
      addr_mem_r[wr_ptr_r] <= addr_mem_r[wr_ptr_r];
      dat_mem_r[wr_ptr_r]  <= dat_mem_r[wr_ptr_r];
    end
  end

  // Output drive
  always_comb begin
    bus.f_ready_out      = f_ready_s;
    bus.d_valid_out      = d_valid_s;
    bus.d_instr_addr_out = head_addr_s;
    bus.d_instr_dat_out  = head_dat_s;
    count_out            = count_r;
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios plus a randomized run
// compared against a queue-based reference model.
module tb_fetch_queue;
  localparam int DEPTH = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clk;
  logic rst;
  logic flush;
  logic [2:0] count;
  int errors;
  int checks;
  logic [63:0] mq [$];

  fetch_queue_if #(.AW(AW), .DW(DW)) bus ();

  fetch_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst), .flush_in(flush), .bus(bus), .count_out(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and update the reference model from the applied inputs.
  task automatic cycle();
    int sz;
    bit push;
    bit pop;
    bit byp;
    logic [63:0] drop;
    sz = mq.size();
    byp = 1'b0;
`ifdef FETCH_QUEUE_BYPASS_EN
    byp = (sz == 0) && bus.f_valid_in;
`endif
    push = bus.f_valid_in && (sz != DEPTH) && !flush && !rst;
    pop = bus.d_ready_in && (sz != 0) && !flush && !rst && !byp;
    @(posedge clk);
    if (rst || flush) begin
      mq.delete();
    end else begin
      if (pop) drop = mq.pop_front();
      if (push && !(byp && bus.d_ready_in)) mq.push_back({bus.f_instr_addr_in, bus.f_instr_dat_in});
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.f_valid_in = 1'b0;
    bus.d_ready_in = 1'b0;
    bus.f_instr_addr_in = 32'h0;
    bus.f_instr_dat_in = 32'h0;
    flush = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    #2;
    checks++; if (bus.d_valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b exp=0", bus.d_valid_out); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (bus.f_ready_out !== 1'b0) begin errors++; $display("FAIL reset_ready got=%0b exp=0", bus.f_ready_out); end
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    mq.delete();
    #1;
    checks++; if (bus.f_ready_out !== 1'b1) begin errors++; $display("FAIL reset_release_ready got=%0b exp=1", bus.f_ready_out); end
    @(negedge clk);
  endtask

  task automatic test_first_push();
    bus.f_valid_in = 1'b1; bus.f_instr_addr_in = 32'h1000; bus.f_instr_dat_in = 32'h00000013;
    cycle();
    bus.f_valid_in = 1'b0;
    #1;
    checks++; if (bus.d_valid_out !== 1'b1) begin errors++; $display("FAIL first_valid got=%0b exp=1", bus.d_valid_out); end
    checks++; if (bus.d_instr_addr_out !== 32'h1000) begin errors++; $display("FAIL first_addr got=%h exp=00001000", bus.d_instr_addr_out); end
    checks++; if (bus.d_instr_dat_out !== 32'h00000013) begin errors++; $display("FAIL first_dat got=%h exp=00000013", bus.d_instr_dat_out); end
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL first_count got=%0d exp=1", count); end
    bus.d_ready_in = 1'b1;
    cycle();
    bus.d_ready_in = 1'b0;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL first_drain got=%0d exp=0", count); end
  endtask

  task automatic test_fill_drain();
    logic [31:0] a;
    for (int i = 0; i < 4; i++) begin
      bus.f_valid_in = 1'b1; bus.f_instr_addr_in = 32'(i * 4); bus.f_instr_dat_in = 32'hA000_0000 + 32'(i);
      cycle();
    end
    bus.f_instr_addr_in = 32'h10;
    #1;
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL fill_count got=%0d exp=4", count); end
    checks++; if (bus.f_ready_out !== 1'b0) begin errors++; $display("FAIL fill_ready got=%0b exp=0", bus.f_ready_out); end
    cycle();
    bus.f_valid_in = 1'b0;
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL fifth_push count got=%0d exp=4", count); end
    bus.d_ready_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a = 32'(i * 4);
      #1;
      checks++; if (bus.d_valid_out !== 1'b1 || bus.d_instr_addr_out !== a) begin
        errors++; $display("FAIL drain_order[%0d] got v=%0b a=%h exp v=1 a=%h", i, bus.d_valid_out, bus.d_instr_addr_out, a);
      end
      cycle();
    end
    bus.d_ready_in = 1'b0;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL drain_count got=%0d exp=0", count); end
  endtask

  task automatic test_stream();
    logic [31:0] a;
    bus.d_ready_in = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.f_valid_in = 1'b1; bus.f_instr_addr_in = 32'h100 + 32'(4 * i); bus.f_instr_dat_in = 32'hB000_0000 + 32'(i);
      #1;
`ifdef FETCH_QUEUE_BYPASS_EN
      a = 32'h100 + 32'(4 * i);
      checks++; if (bus.d_valid_out !== 1'b1 || bus.d_instr_addr_out !== a || count !== 3'd0) begin
        errors++; $display("FAIL stream[%0d] got v=%0b a=%h c=%0d exp v=1 a=%h c=0", i, bus.d_valid_out, bus.d_instr_addr_out, count, a);
      end
`else
      if (i > 0) begin
        a = 32'h100 + 32'(4 * (i - 1));
        checks++; if (bus.d_valid_out !== 1'b1 || bus.d_instr_addr_out !== a || count !== 3'd1) begin
          errors++; $display("FAIL stream[%0d] got v=%0b a=%h c=%0d exp v=1 a=%h c=1", i, bus.d_valid_out, bus.d_instr_addr_out, count, a);
        end
      end
`endif
      cycle();
    end
    bus.f_valid_in = 1'b0;
    cycle();
    bus.d_ready_in = 1'b0;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL stream_end count got=%0d exp=0", count); end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) begin
      bus.f_valid_in = 1'b1; bus.f_instr_addr_in = 32'h200 + 32'(4 * i); bus.f_instr_dat_in = 32'(i);
      cycle();
    end
    flush = 1'b1; bus.f_valid_in = 1'b1; bus.f_instr_addr_in = 32'h300; bus.d_ready_in = 1'b1;
    #1;
    checks++; if (bus.d_valid_out !== 1'b0) begin errors++; $display("FAIL flush_cycle_valid got=%0b exp=0", bus.d_valid_out); end
    cycle();
    flush = 1'b0; bus.f_valid_in = 1'b0; bus.d_ready_in = 1'b0;
    #1;
    checks++; if (count !== 3'd0 || bus.d_valid_out !== 1'b0) begin
      errors++; $display("FAIL flush_after got c=%0d v=%0b exp c=0 v=0", count, bus.d_valid_out);
    end
    bus.f_valid_in = 1'b1; bus.f_instr_addr_in = 32'h400;
    cycle();
    bus.f_valid_in = 1'b0;
    #1;
    checks++; if (bus.d_instr_addr_out !== 32'h400 || count !== 3'd1) begin
      errors++; $display("FAIL flush_next_head got a=%h c=%0d exp a=00000400 c=1", bus.d_instr_addr_out, count);
    end
    bus.d_ready_in = 1'b1;
    cycle();
    bus.d_ready_in = 1'b0;
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 2; i++) begin
      bus.f_valid_in = 1'b1; bus.f_instr_addr_in = 32'h600 + 32'(4 * i);
      cycle();
    end
    bus.f_valid_in = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checks++; if (bus.d_valid_out !== 1'b0 || count !== 3'd0 || bus.f_ready_out !== 1'b0) begin
      errors++; $display("FAIL async_reset got v=%0b c=%0d r=%0b exp v=0 c=0 r=0", bus.d_valid_out, count, bus.f_ready_out);
    end
    mq.delete();
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (bus.f_ready_out !== 1'b1 || count !== 3'd0) begin
      errors++; $display("FAIL async_release got r=%0b c=%0d exp r=1 c=0", bus.f_ready_out, count);
    end
    @(negedge clk);
  endtask

`ifdef FETCH_QUEUE_BYPASS_EN
  task automatic test_bypass();
    bus.f_valid_in = 1'b1; bus.d_ready_in = 1'b1; bus.f_instr_addr_in = 32'h500; bus.f_instr_dat_in = 32'hCAFE_0001;
    #1;
    checks++; if (bus.d_valid_out !== 1'b1 || bus.d_instr_addr_out !== 32'h500 || bus.d_instr_dat_out !== 32'hCAFE_0001) begin
      errors++; $display("FAIL bypass_fwd got v=%0b a=%h d=%h", bus.d_valid_out, bus.d_instr_addr_out, bus.d_instr_dat_out);
    end
    cycle();
    bus.f_valid_in = 1'b0; bus.d_ready_in = 1'b0;
    #1;
    checks++; if (count !== 3'd0 || bus.d_valid_out !== 1'b0) begin
      errors++; $display("FAIL bypass_count got c=%0d v=%0b exp c=0 v=0", count, bus.d_valid_out);
    end
  endtask
`endif

  task automatic test_random();
    bit ev;
    logic [31:0] ea;
    logic [31:0] ed;
    int sz;
    for (int n = 0; n < 400; n++) begin
      bus.f_valid_in = ($urandom_range(0, 3) != 0);
      bus.d_ready_in = ($urandom_range(0, 2) != 0) ^ (n[6]);
      flush = ($urandom_range(0, 15) == 0);
      bus.f_instr_addr_in = $urandom;
      bus.f_instr_dat_in = $urandom;
      #1;
      sz = mq.size();
      ev = (sz != 0) && !flush;
      ea = (sz != 0) ? mq[0][63:32] : 32'h0;
      ed = (sz != 0) ? mq[0][31:0] : 32'h0;
`ifdef FETCH_QUEUE_BYPASS_EN
      if (sz == 0 && bus.f_valid_in) begin
        ev = !flush; ea = bus.f_instr_addr_in; ed = bus.f_instr_dat_in;
      end
`endif
      checks++; if (count !== 3'(sz) || bus.f_ready_out !== (sz != DEPTH) || bus.d_valid_out !== ev) begin
        errors++; $display("FAIL rand_ctl[%0d] got c=%0d r=%0b v=%0b exp c=%0d r=%0b v=%0b", n, count, bus.f_ready_out, bus.d_valid_out, sz, (sz != DEPTH), ev);
      end
      if (ev) begin
        checks++; if (bus.d_instr_addr_out !== ea || bus.d_instr_dat_out !== ed) begin
          errors++; $display("FAIL rand_head[%0d] got a=%h d=%h exp a=%h d=%h", n, bus.d_instr_addr_out, bus.d_instr_dat_out, ea, ed);
        end
      end
      cycle();
    end
    idle_inputs();
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_first_push();
    test_fill_drain();
    test_stream();
    test_flush();
    test_async_reset();
`ifdef FETCH_QUEUE_BYPASS_EN
    test_bypass();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
